// File: rtl/dmem_block_responder.sv
// Block-level data memory responder: stalls the dcache for LATENCY clocks, then commits a write or returns a block.
// Optional DMEM_RESPONDER_STATS_EN adds saturating read/write completion counters.
module dmem_block_responder #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 5
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_writedata,
  output logic [DATA_WIDTH-1:0] mem_readdata,
  output logic                  mem_busywait
`ifdef DMEM_RESPONDER_STATS_EN
  ,
  output logic [15:0]           read_count,
  output logic [15:0]           write_count
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state_reg;
  logic [7:0]              counter_reg;
  logic                    op_write_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic [DATA_WIDTH-1:0]   mem_reg [DEPTH];
  logic                    complete;

  assign complete = (state_reg == BUSY) && (counter_reg == 8'(LATENCY));

  // Stall is held low throughout reset regardless of the request strobes.
  always_comb begin
    mem_busywait = 1'b0;
    if (RESET_N) begin
      case (state_reg)
        IDLE:    mem_busywait = mem_read | mem_write;
        BUSY:    mem_busywait = 1'b1;
        default: mem_busywait = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg    <= IDLE;
      counter_reg  <= '0;
      op_write_reg <= 1'b0;
      addr_reg     <= '0;
      data_reg     <= '0;
      mem_readdata <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (mem_read | mem_write) begin
            op_write_reg <= mem_write;
            addr_reg     <= mem_address;
            data_reg     <= mem_writedata;
            counter_reg  <= 8'd1;
            state_reg    <= BUSY;
          end
        end
        BUSY: begin
          if (complete) begin
            if (!op_write_reg) begin
              mem_readdata <= mem_reg[addr_reg];
            end
            state_reg <= DONE;
          end else begin
            counter_reg <= counter_reg + 8'd1;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Storage clears on reset, so it lives in flops rather than a RAM primitive.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (complete && op_write_reg) begin
      mem_reg[addr_reg] <= data_reg;
    end
  end

`ifdef DMEM_RESPONDER_STATS_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      read_count  <= '0;
      write_count <= '0;
    end else if (complete) begin
      if (op_write_reg) begin
        if (write_count != 16'hFFFF) write_count <= write_count + 16'd1;
      end else begin
        if (read_count != 16'hFFFF) read_count <= read_count + 16'd1;
      end
    end
  end
`endif

endmodule
